// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM bridge port between instruction fetch (port 0) and load/store (port 1).
// Strobe 1 cycle after request, mN_ack 1 cycle after bridge ack; SDRAM_ARB_TIMEOUT_EN adds a BUSY abort timer.
module sdram_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [21:0] m0_address,
   input  logic [3:0]  m0_byte_enable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_write_data,
   output logic        m0_ack,
   output logic [31:0] m0_read_data,
   output logic        m0_error,
   input  logic [21:0] m1_address,
   input  logic [3:0]  m1_byte_enable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_write_data,
   output logic        m1_ack,
   output logic [31:0] m1_read_data,
   output logic        m1_error,
   output logic [21:0] sdram_address,
   output logic [3:0]  sdram_byte_enable,
   output logic        sdram_read,
   output logic        sdram_write,
   output logic [31:0] sdram_write_data,
   input  logic        sdram_acknowledge,
   input  logic [31:0] sdram_read_data
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_grant, w_grant_nxt;
   logic        r_last, w_last_nxt;
   logic [21:0] r_addr, w_addr_nxt;
   logic [3:0]  r_be, w_be_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic        r_rd, w_rd_nxt;
   logic        r_wr, w_wr_nxt;
   logic        r_ack0, w_ack0_nxt;
   logic        r_ack1, w_ack1_nxt;
   logic [31:0] r_rdata0, w_rdata0_nxt;
   logic [31:0] r_rdata1, w_rdata1_nxt;
   logic        w_req0, w_req1, w_sel, w_sel_wr, w_expire;
   logic [31:0] w_resp_data;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;
   // On contention the port that was not granted last time wins.
   assign w_sel    = (w_req0 & w_req1) ? ~r_last : w_req1;
   assign w_sel_wr = w_sel ? m1_write : m0_write;
   assign w_resp_data = (sdram_acknowledge & ~r_wr) ? sdram_read_data : 32'h0;

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_last_nxt   = r_last;
      w_addr_nxt   = r_addr;
      w_be_nxt     = r_be;
      w_wdata_nxt  = r_wdata;
      w_rd_nxt     = r_rd;
      w_wr_nxt     = r_wr;
      w_ack0_nxt   = 1'b0;
      w_ack1_nxt   = 1'b0;
      w_rdata0_nxt = 32'h0;
      w_rdata1_nxt = 32'h0;
      case (r_state)
         IDLE: begin
            if (w_req0 | w_req1) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_sel;
               w_last_nxt  = w_sel;
               w_addr_nxt  = w_sel ? m1_address     : m0_address;
               w_be_nxt    = w_sel ? m1_byte_enable : m0_byte_enable;
               w_wdata_nxt = w_sel ? m1_write_data  : m0_write_data;
               w_wr_nxt    = w_sel_wr;
               w_rd_nxt    = ~w_sel_wr;
            end
         end
         BUSY: begin
            // A bridge ack in the expiry cycle takes precedence over the abort.
            if (sdram_acknowledge | w_expire) begin
               w_state_nxt = RESP;
               w_rd_nxt    = 1'b0;
               w_wr_nxt    = 1'b0;
               if (r_grant) begin
                  w_ack1_nxt   = 1'b1;
                  w_rdata1_nxt = w_resp_data;
               end else begin
                  w_ack0_nxt   = 1'b1;
                  w_rdata0_nxt = w_resp_data;
               end
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_grant  <= 1'b0;
         r_last   <= 1'b1;
         r_addr   <= '0;
         r_be     <= '0;
         r_wdata  <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_last   <= w_last_nxt;
         r_addr   <= w_addr_nxt;
         r_be     <= w_be_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rd     <= w_rd_nxt;
         r_wr     <= w_wr_nxt;
         r_ack0   <= w_ack0_nxt;
         r_ack1   <= w_ack1_nxt;
         r_rdata0 <= w_rdata0_nxt;
         r_rdata1 <= w_rdata1_nxt;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_err0, r_err1;

   // Counter holds the number of ack-less BUSY cycles already elapsed.
   assign w_expire = (r_state == BUSY) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tmo_cnt <= '0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
      end else begin
         if (r_state != BUSY) begin
            r_tmo_cnt <= '0;
         end else if (!sdram_acknowledge) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         r_err0 <= w_expire & ~sdram_acknowledge & ~r_grant;
         r_err1 <= w_expire & ~sdram_acknowledge & r_grant;
      end
   end

   assign m0_error = r_err0;
   assign m1_error = r_err1;
`else
   assign w_expire = 1'b0;
   assign m0_error = 1'b0;
   assign m1_error = 1'b0;
`endif

   assign sdram_address     = r_addr;
   assign sdram_byte_enable = r_be;
   assign sdram_write_data  = r_wdata;
   assign sdram_read        = r_rd;
   assign sdram_write       = r_wr;
   assign m0_ack            = r_ack0;
   assign m1_ack            = r_ack1;
   assign m0_read_data      = r_rdata0;
   assign m1_read_data      = r_rdata1;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: bus and response expectations are queued by stimulus, checked by a monitor.
module tb_sdram_port_arbiter;
   logic        clk;
   logic        reset_n;
   logic [21:0] m0_address, m1_address;
   logic [3:0]  m0_byte_enable, m1_byte_enable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_write_data, m1_write_data;
   logic        m0_ack, m1_ack, m0_error, m1_error;
   logic [31:0] m0_read_data, m1_read_data;
   logic [21:0] sdram_address;
   logic [3:0]  sdram_byte_enable;
   logic        sdram_read, sdram_write;
   logic [31:0] sdram_write_data;
   logic        sdram_acknowledge;
   logic [31:0] sdram_read_data;

   typedef struct {
      logic        wr;
      logic [21:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          exp_cyc;
   } bus_t;
   typedef struct {
      int          lat;
      logic [31:0] data;
   } brg_t;
   typedef struct {
      int          port;
      logic [31:0] data;
      logic        err;
      int          dly;
   } rsp_t;

   bus_t bus_q[$];
   brg_t brg_q[$];
   rsp_t rsp_q[$];

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   bus_t cur_bus;
   logic prev_stb = 1'b0;

   sdram_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byte_enable(m0_byte_enable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_write_data(m0_write_data), .m0_ack(m0_ack),
      .m0_read_data(m0_read_data), .m0_error(m0_error),
      .m1_address(m1_address), .m1_byte_enable(m1_byte_enable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_write_data(m1_write_data), .m1_ack(m1_ack),
      .m1_read_data(m1_read_data), .m1_error(m1_error),
      .sdram_address(sdram_address), .sdram_byte_enable(sdram_byte_enable),
      .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_write_data(sdram_write_data),
      .sdram_acknowledge(sdram_acknowledge), .sdram_read_data(sdram_read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int port, input logic rd, input logic wr, input logic [21:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      if (port == 1) begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_byte_enable = be; m1_write_data = wd;
      end else begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_byte_enable = be; m0_write_data = wd;
      end
   endtask

   // Requester: hold until ack, drop the cycle after ack, re-request one cycle later.
   task automatic do_req(input int port, input logic rd, input logic wr, input logic [21:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         drive(port, rd, wr, addr, be, wd);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!(port == 1 ? m1_ack : m0_ack) && t < 100);
         chk($sformatf("ack_arrived_p%0d", port), (port == 1 ? m1_ack : m0_ack), 1);
         @(posedge clk); #1;
         drive(port, 1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
         if (i < n - 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // Bridge model: acks in BUSY cycle index lat (0 = first), never when lat < 0.
   initial begin
      brg_t cur;
      int   k;
      cur = '{-1, 32'h0};
      k = 0;
      sdram_acknowledge = 1'b0;
      sdram_read_data = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset_n || sdram_acknowledge) begin
            sdram_acknowledge = 1'b0;
            sdram_read_data = 32'h0;
            k = 0;
         end else if (sdram_read | sdram_write) begin
            if (k == 0) begin
               if (brg_q.size() > 0) cur = brg_q.pop_front();
               else cur = '{-1, 32'h0};
            end
            sdram_read_data = cur.data;
            if (k == cur.lat) sdram_acknowledge = 1'b1;
            k++;
         end else begin
            sdram_read_data = 32'h0;
            k = 0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic stb;
      rsp_t r;
      int   port;
      if (!reset_n) begin
         prev_stb = 1'b0;
      end else begin
         stb = sdram_read | sdram_write;
         if (stb && !prev_stb) begin
            chk("grant_expected", bus_q.size() > 0, 1);
            if (bus_q.size() > 0) begin
               cur_bus = bus_q.pop_front();
               grant_cyc = cyc;
               if (cur_bus.exp_cyc >= 0) chk("grant_cycle", cyc, cur_bus.exp_cyc);
            end
         end
         if (stb) begin
            chk("bus_write", sdram_write, cur_bus.wr);
            chk("bus_read", sdram_read, !cur_bus.wr);
            chk("bus_address", sdram_address, cur_bus.addr);
            chk("bus_byte_enable", sdram_byte_enable, cur_bus.be);
            chk("bus_write_data", sdram_write_data, cur_bus.wdata);
         end
         if (m0_ack || m1_ack) begin
            chk("single_ack", m0_ack & m1_ack, 0);
            chk("ack_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
               r = rsp_q.pop_front();
               port = m1_ack ? 1 : 0;
               chk("ack_port", port, r.port);
               chk("ack_read_data", port == 1 ? m1_read_data : m0_read_data, r.data);
               chk("ack_error", port == 1 ? m1_error : m0_error, r.err);
               chk("ack_latency", cyc - grant_cyc, r.dly);
               chk("other_port_quiet", port == 1 ? {m0_read_data, m0_error} : {m1_read_data, m1_error}, 0);
               chk("strobe_low_at_ack", stb, 0);
            end
         end
         prev_stb = stb;
      end
   end

   initial begin
      int c;
      int t;
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sdram_read", sdram_read, 0);
      chk("rst_sdram_write", sdram_write, 0);
      chk("rst_sdram_address", sdram_address, 0);
      chk("rst_sdram_be", sdram_byte_enable, 0);
      chk("rst_sdram_wdata", sdram_write_data, 0);
      chk("rst_acks", {m0_ack, m1_ack, m0_error, m1_error}, 0);
      chk("rst_read_data", {m0_read_data, m1_read_data}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Port-0 read, bridge acks 3 cycles after the strobe rises.
      @(posedge clk); #1;
      c = cyc;
      bus_q.push_back('{1'b0, 22'h000100, 4'h0, 32'h0, c + 1});
      brg_q.push_back('{3, 32'hDEADBEEF});
      rsp_q.push_back('{0, 32'hDEADBEEF, 1'b0, 4});
      do_req(0, 1'b1, 1'b0, 22'h000100, 4'h0, 32'h0, 1);

      // Fresh reset, then contention with re-requests: grant order 0,1,0,1.
      @(posedge clk); #1; reset_n = 1'b0;
      @(posedge clk); #1; reset_n = 1'b1;
      @(posedge clk); #1;
      c = cyc;
      bus_q.push_back('{1'b0, 22'h000010, 4'h3, 32'h0, c + 1});
      bus_q.push_back('{1'b1, 22'h3FFFFF, 4'hF, 32'hCAFEF00D, -1});
      bus_q.push_back('{1'b0, 22'h000010, 4'h3, 32'h0, -1});
      bus_q.push_back('{1'b1, 22'h3FFFFF, 4'hF, 32'hCAFEF00D, -1});
      brg_q.push_back('{1, 32'h11111111});
      brg_q.push_back('{2, 32'h55555555});
      brg_q.push_back('{0, 32'h22222222});
      brg_q.push_back('{1, 32'h66666666});
      rsp_q.push_back('{0, 32'h11111111, 1'b0, 2});
      rsp_q.push_back('{1, 32'h0, 1'b0, 3});
      rsp_q.push_back('{0, 32'h22222222, 1'b0, 1});
      rsp_q.push_back('{1, 32'h0, 1'b0, 2});
      fork
         do_req(0, 1'b1, 1'b0, 22'h000010, 4'h3, 32'h0, 2);
         do_req(1, 1'b0, 1'b1, 22'h3FFFFF, 4'hF, 32'hCAFEF00D, 2);
      join

      // Immediate acks: request->ack 2 cycles, grant->grant 3 cycles; port 1 read+write acts as write.
      @(posedge clk); #1;
      c = cyc;
      bus_q.push_back('{1'b0, 22'h2AAAAA, 4'h8, 32'h0, c + 1});
      bus_q.push_back('{1'b1, 22'h155555, 4'hC, 32'h0F0F0F0F, c + 4});
      brg_q.push_back('{0, 32'hAAAA5555});
      brg_q.push_back('{0, 32'h77777777});
      rsp_q.push_back('{0, 32'hAAAA5555, 1'b0, 1});
      rsp_q.push_back('{1, 32'h0, 1'b0, 1});
      fork
         do_req(0, 1'b1, 1'b0, 22'h2AAAAA, 4'h8, 32'h0, 1);
         do_req(1, 1'b1, 1'b1, 22'h155555, 4'hC, 32'h0F0F0F0F, 1);
      join

      // Reset during a port-0 write that is never acknowledged.
      @(posedge clk); #1;
      c = cyc;
      bus_q.push_back('{1'b1, 22'h0ABCDE, 4'h5, 32'hA5A5A5A5, c + 1});
      brg_q.push_back('{-1, 32'h0});
      drive(0, 1'b0, 1'b1, 22'h0ABCDE, 4'h5, 32'hA5A5A5A5);
      repeat (3) @(posedge clk);
      #3;
      chk("busy_before_reset", sdram_write, 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_write", sdram_write, 0);
      chk("async_rst_read", sdram_read, 0);
      chk("async_rst_address", sdram_address, 0);
      drive(0, 1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      c = cyc;
      bus_q.push_back('{1'b0, 22'h000ABC, 4'h1, 32'h0, c + 1});
      bus_q.push_back('{1'b0, 22'h000DEF, 4'h2, 32'h0, -1});
      brg_q.push_back('{1, 32'h0BADF00D});
      brg_q.push_back('{1, 32'h600DF00D});
      rsp_q.push_back('{0, 32'h0BADF00D, 1'b0, 2});
      rsp_q.push_back('{1, 32'h600DF00D, 1'b0, 2});
      fork
         do_req(0, 1'b1, 1'b0, 22'h000ABC, 4'h1, 32'h0, 1);
         do_req(1, 1'b1, 1'b0, 22'h000DEF, 4'h2, 32'h0, 1);
      join

`ifdef SDRAM_ARB_TIMEOUT_EN
      // No acknowledge: abort after 8 BUSY cycles with error and zero data.
      @(posedge clk); #1;
      bus_q.push_back('{1'b0, 22'h000777, 4'h0, 32'h0, -1});
      brg_q.push_back('{-1, 32'hBADBAD00});
      rsp_q.push_back('{1, 32'h0, 1'b1, 8});
      do_req(1, 1'b1, 1'b0, 22'h000777, 4'h0, 32'h0, 1);
      // Acknowledge exactly in the expiry cycle completes normally.
      @(posedge clk); #1;
      bus_q.push_back('{1'b0, 22'h000888, 4'h0, 32'h0, -1});
      brg_q.push_back('{7, 32'h13579BDF});
      rsp_q.push_back('{0, 32'h13579BDF, 1'b0, 8});
      do_req(0, 1'b1, 1'b0, 22'h000888, 4'h0, 32'h0, 1);
`endif

      t = 0;
      while ((rsp_q.size() > 0 || bus_q.size() > 0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("bus_queue_drained", bus_q.size(), 0);
      chk("bridge_queue_drained", brg_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
